ram_cmd_scheduler: RTL
======================

# ram_cmd_scheduler

Front-end command scheduler for the 8-bank DDR-style RAM model. It arbitrates read/write requests from two requesters and tracks the open row of every bank. It sequences PRE/ACT/RD/WR/REF commands onto the RAM command bus under programmable tRP/tRCD/tRFC spacing, and returns read data to the requester that issued the read. It sits between the host-side traffic sources and the RAM controller interface, and owns all periodic refresh.

## Interface
- T_RCD, 2: cycles from ACT to RD/WR, minimum 1.
- T_RP, 2: cycles from PRE/PREA to the next ACT or REF, minimum 1.
- T_RFC, 5: cycles from REF until the next command.
- REF_INTERVAL, 64: cycles between refresh requests.
- RD_LAT, 2: cycles from the RD command to `dram_rdata` being valid.
- `clk_t` in 1: the single clock; everything is sampled on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `reqN_valid` in 1, for N = 0, 1: request present.
- `reqN_ready` out 1: request accepted when valid && ready.
- `reqN_rwb` in 1: 1 = write, 0 = read.
- `reqN_addr` in 9: {bank_grp, bank_no[1:0], row[2:0], col[2:0]}.
- `reqN_wdata` in 16: write data.
- `cmd_valid` out 1: command qualifier.
- `cmd` out 3: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF.
- `cmd_bank` out 3: {bank_grp, bank_no}.
- `cmd_row` out 3, `cmd_col` out 3: row and column address.
- `cmd_auto_pre` out 1: auto-precharge on RD/WR.
- `cmd_wdata` out 16: write data, valid with WR.
- `dram_rdata` in 16: read data from the RAM.
- `rsp_valid` out 1: one-cycle read response strobe.
- `rsp_id` out 1: requester that issued the read.
- `rsp_rdata` out 16: read data.

## Operation
- Per bank it holds `open[b]` (1 bit) and `open_row[b]` (3 bits). Reset clears every `open[b]`.
- FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, ISSUE, REF_PREA, REF_WAIT_RP, REF, WAIT_RFC.
- IDLE, refresh has priority: if `ref_pending` is set, no ready is raised and the FSM goes to REF_PREA.
  - REF_PREA issues PREA only if any bank is open; otherwise it goes straight to REF.
- IDLE, request path: round-robin between the two requesters.
  - A `last_grant` bit resets to 1, so requester 0 wins the first tie.
  - With a single valid requester, that requester is granted.
  - `ready` is combinational: asserted only in IDLE, to the granted requester, when `ref_pending` is 0.
- On acceptance the request is latched (id, rwb, addr, wdata). The next state depends on the target bank:
  - row hit → ISSUE;
  - bank closed → ACT;
  - row miss → PRE.
- PRE: issue PRE to the bank, clear `open[b]`, go to WAIT_RP for T_RP−1 cycles, then ACT.
- ACT: issue ACT, set `open[b]` and `open_row[b]`, go to WAIT_RCD for T_RCD−1 cycles, then ISSUE.
- ISSUE: issue RD or WR with the latched col/wdata, then return to IDLE.
- Read return: a RD launches an RD_LAT-deep shift of {valid, id}. When it emerges, `rsp_valid` pulses and `rsp_rdata` = `dram_rdata` in that cycle.
  - Back-to-back reads must both return; the pipeline needs no stall.
- Refresh counter: counts every cycle. On reaching REF_INTERVAL−1 it sets `ref_pending` and holds.
  - In REF: issue REF, clear `ref_pending` and the counter, clear all `open[b]`.
  - Then wait T_RFC−1 cycles in WAIT_RFC and return to IDLE.
- A refresh that comes due mid-transaction waits until the FSM is back in IDLE; an in-flight PRE→ACT→ISSUE sequence is never aborted.
- `reset_n` low in any state forces IDLE next cycle, clears all banks, counters, pending flags and the read pipeline. Any in-flight read response is dropped.

## Timing
- Reset values: `reqN_ready` 0, `cmd_valid` 0, `cmd` NOP, `cmd_bank`/`cmd_row`/`cmd_col` 0, `cmd_auto_pre` 0, `cmd_wdata` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_rdata` 0.
- Command outputs are registered. In non-command cycles, `cmd_valid` = 0 and `cmd` = NOP.
- Command schedule, with acceptance in cycle N:
  - row hit: RD/WR at N+1;
  - closed bank: ACT at N+1, RD/WR at N+1+T_RCD;
  - row miss: PRE at N+1, ACT at N+1+T_RP, RD/WR at N+1+T_RP+T_RCD.
- `rsp_valid` is asserted at cycle (RD cycle)+RD_LAT.
- Next acceptance is possible, at the earliest, the cycle after RD/WR. Maximum throughput is 1 request per 2 cycles on row hits.
- Refresh from IDLE: PREA at M+1, REF at M+1+T_RP (M+1 if no bank is open). IDLE is re-entered at REF+T_RFC.

## Configuration
- `RAM_SCHED_CLOSE_PAGE_EN` defined: close-page policy.
  - Every RD/WR is issued with `cmd_auto_pre` = 1 and clears `open[b]`.
  - The FSM then waits T_RP cycles before returning to IDLE, so every access is ACT+RD/WR. The PRE state is unreachable.
- Undefined: open-page policy as above; `cmd_auto_pre` is always 0.

## Test plan
- Reset, then req0 read of addr 9'h0A5 (bank 2, row 4, col 5) → ACT bank 2 row 4 at N+1, RD col 5 at N+3. When `dram_rdata` = 16'hBEEF at N+5, expect `rsp_valid`=1, `rsp_id`=0, `rsp_rdata`=16'hBEEF.
- Write bank 2 row 4 followed by read bank 2 row 4 → second access issues RD with no ACT, exactly 1 cycle after acceptance.
- Read bank 2 row 4, then read bank 2 row 6 → PRE bank 2, ACT row 6 T_RP cycles later, RD T_RCD cycles after that.
- Both requesters valid continuously → grants alternate 0,1,0,1 starting with requester 0. No request is lost, and `rsp_id` order matches grant order.
- Idle for 64 cycles with bank 1 open → PREA, REF 2 cycles later, next ACT ≥5 cycles after REF. A request held valid during refresh is accepted only after WAIT_RFC.
- Deassert `reset_n` during WAIT_RCD → next cycle all outputs at reset values. The following access to the same bank issues ACT, not a row hit.

Source files
------------

// File: rtl/ram_cmd_scheduler.sv
// ram_cmd_scheduler: front-end command scheduler for the 8-bank RAM model.
// Arbitrates two requesters round-robin and tracks the open row of every bank.
// Sequences PRE/ACT/RD/WR/PREA/REF with tRP/tRCD/tRFC spacing, owns periodic
// refresh, and routes read data back to the requester that issued the read.
//
// Ports:
//   clk_t, reset_n            clock, synchronous active-low reset
//   reqN_valid/ready          request handshake (N = 0, 1)
//   reqN_rwb/addr/wdata       1 = write; addr = {bank[2:0], row[2:0], col[2:0]}
//   cmd_valid, cmd            registered command bus (0 NOP .. 6 REF)
//   cmd_bank/row/col          command address
//   cmd_auto_pre, cmd_wdata   auto-precharge flag, write data with WR
//   dram_rdata                read data from the RAM
//   rsp_valid/id/rdata        one-cycle read response
//
// Build option: define RAM_SCHED_CLOSE_PAGE_EN for a close-page policy (every
// RD/WR auto-precharges, then tRP is observed before returning to idle).
module ram_cmd_scheduler #(
  parameter int unsigned T_RCD        = 2,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RFC        = 5,
  parameter int unsigned REF_INTERVAL = 64,
  parameter int unsigned RD_LAT       = 2
) (
  input  logic        clk_t,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_rwb,
  input  logic [8:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_rwb,
  input  logic [8:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic [2:0]  cmd_bank,
  output logic [2:0]  cmd_row,
  output logic [2:0]  cmd_col,
  output logic        cmd_auto_pre,
  output logic [15:0] cmd_wdata,
  input  logic [15:0] dram_rdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_rdata
);

  localparam logic [2:0] CmdNop  = 3'd0;
  localparam logic [2:0] CmdAct  = 3'd1;
  localparam logic [2:0] CmdRd   = 3'd2;
  localparam logic [2:0] CmdWr   = 3'd3;
  localparam logic [2:0] CmdPre  = 3'd4;
  localparam logic [2:0] CmdPrea = 3'd5;
  localparam logic [2:0] CmdRef  = 3'd6;

  // Wait states hold for (k) cycles: loaded with k-1, leave when the count is 0.
  localparam logic [7:0]  RcdWait = 8'(T_RCD - 2);
  localparam logic [7:0]  RpWait  = 8'(T_RP - 2);
  localparam logic [7:0]  RfcWait = 8'(T_RFC - 2);
  localparam logic [15:0] RefLast = 16'(REF_INTERVAL - 1);
`ifdef RAM_SCHED_CLOSE_PAGE_EN
  localparam logic       AutoPre   = 1'b1;
  localparam logic [7:0] IssueWait = 8'(T_RP - 1);
`else
  localparam logic       AutoPre   = 1'b0;
`endif

  typedef enum logic [3:0] {
    StIdle, StPre, StWaitRp, StAct, StWaitRcd, StIssue,
    StRefPrea, StRefWaitRp, StRef, StWaitRfc
  } state_e;

  state_e            state_q;
  logic [7:0]        wait_q;
  logic              id_q, rwb_q;
  logic [8:0]        addr_q;
  logic [15:0]       wdata_q;
  logic [7:0]        open_q;
  logic [2:0]        open_row_q [8];
  logic              last_grant_q, ref_pending_q;
  logic [15:0]       ref_cnt_q;
  logic [RD_LAT-1:0] rd_vld_q, rd_id_q;
  logic              cmd_valid_q, cmd_auto_pre_q;
  logic [2:0]        cmd_q, cmd_bank_q, cmd_row_q, cmd_col_q;
  logic [15:0]       cmd_wdata_q;

  logic        grant_id, accept_en, acc_valid, acc_rwb;
  logic [8:0]  acc_addr;
  logic [15:0] acc_wdata;
  logic [2:0]  acc_bank, acc_row, lat_bank, lat_row, lat_col;

  // Round-robin: on a tie the requester not granted last time wins.
  always_comb begin
    grant_id = ~last_grant_q;
    if (req0_valid && !req1_valid)      grant_id = 1'b0;
    else if (req1_valid && !req0_valid) grant_id = 1'b1;
  end

  assign accept_en  = reset_n && (state_q == StIdle) && !ref_pending_q;
  assign req0_ready = accept_en && !grant_id;
  assign req1_ready = accept_en && grant_id;
  assign acc_valid  = grant_id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  assign acc_rwb    = grant_id ? req1_rwb : req0_rwb;
  assign acc_addr   = grant_id ? req1_addr : req0_addr;
  assign acc_wdata  = grant_id ? req1_wdata : req0_wdata;
  assign acc_bank   = acc_addr[8:6];
  assign acc_row    = acc_addr[5:3];
  assign lat_bank   = addr_q[8:6];
  assign lat_row    = addr_q[5:3];
  assign lat_col    = addr_q[2:0];

  always_ff @(posedge clk_t) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      wait_q         <= '0;
      id_q           <= 1'b0;
      rwb_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      open_q         <= '0;
      for (int b = 0; b < 8; b++) open_row_q[b] <= '0;
      last_grant_q   <= 1'b1;
      ref_pending_q  <= 1'b0;
      ref_cnt_q      <= '0;
      rd_vld_q       <= '0;
      rd_id_q        <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_q          <= CmdNop;
      cmd_bank_q     <= '0;
      cmd_row_q      <= '0;
      cmd_col_q      <= '0;
      cmd_auto_pre_q <= 1'b0;
      cmd_wdata_q    <= '0;
    end else begin
      cmd_valid_q    <= 1'b0;
      cmd_q          <= CmdNop;
      cmd_bank_q     <= '0;
      cmd_row_q      <= '0;
      cmd_col_q      <= '0;
      cmd_auto_pre_q <= 1'b0;
      cmd_wdata_q    <= '0;

      // Read return shift: a RD on the bus this cycle emerges RD_LAT cycles later.
      rd_vld_q[0] <= (state_q == StIssue) && !rwb_q;
      rd_id_q[0]  <= id_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_id_q[i]  <= rd_id_q[i-1];
      end

      if (!ref_pending_q) begin
        if (ref_cnt_q == RefLast) ref_pending_q <= 1'b1;
        else                      ref_cnt_q     <= ref_cnt_q + 16'd1;
      end

      // Each transition registers the command that is on the bus in the new state.
      case (state_q)
        StIdle: begin
          if (ref_pending_q) begin
            cmd_valid_q <= 1'b1;
            open_q      <= '0;
            if (|open_q) begin
              cmd_q   <= CmdPrea;
              state_q <= StRefPrea;
            end else begin
              cmd_q         <= CmdRef;
              ref_pending_q <= 1'b0;
              ref_cnt_q     <= '0;
              state_q       <= StRef;
            end
          end else if (acc_valid) begin
            id_q         <= grant_id;
            rwb_q        <= acc_rwb;
            addr_q       <= acc_addr;
            wdata_q      <= acc_wdata;
            last_grant_q <= grant_id;
            cmd_valid_q  <= 1'b1;
            cmd_bank_q   <= acc_bank;
            cmd_row_q    <= acc_row;
            if (open_q[acc_bank] && (open_row_q[acc_bank] == acc_row)) begin
              cmd_q          <= acc_rwb ? CmdWr : CmdRd;
              cmd_col_q      <= acc_addr[2:0];
              cmd_auto_pre_q <= AutoPre;
              cmd_wdata_q    <= acc_wdata;
              state_q        <= StIssue;
            end else if (open_q[acc_bank]) begin
              cmd_q            <= CmdPre;
              open_q[acc_bank] <= 1'b0;
              state_q          <= StPre;
            end else begin
              cmd_q                <= CmdAct;
              open_q[acc_bank]     <= 1'b1;
              open_row_q[acc_bank] <= acc_row;
              state_q              <= StAct;
            end
          end
        end
        StPre, StWaitRp: begin
          if (state_q == StPre && T_RP > 1) begin
            wait_q  <= RpWait;
            state_q <= StWaitRp;
          end else if (state_q == StWaitRp && wait_q != 8'd0) begin
            wait_q <= wait_q - 8'd1;
          end else begin
`ifdef RAM_SCHED_CLOSE_PAGE_EN
            state_q <= StIdle;
`else
            cmd_valid_q          <= 1'b1;
            cmd_q                <= CmdAct;
            cmd_bank_q           <= lat_bank;
            cmd_row_q            <= lat_row;
            open_q[lat_bank]     <= 1'b1;
            open_row_q[lat_bank] <= lat_row;
            state_q              <= StAct;
`endif
          end
        end
        StAct, StWaitRcd: begin
          if (state_q == StAct && T_RCD > 1) begin
            wait_q  <= RcdWait;
            state_q <= StWaitRcd;
          end else if (state_q == StWaitRcd && wait_q != 8'd0) begin
            wait_q <= wait_q - 8'd1;
          end else begin
            cmd_valid_q    <= 1'b1;
            cmd_q          <= rwb_q ? CmdWr : CmdRd;
            cmd_bank_q     <= lat_bank;
            cmd_row_q      <= lat_row;
            cmd_col_q      <= lat_col;
            cmd_auto_pre_q <= AutoPre;
            cmd_wdata_q    <= wdata_q;
            state_q        <= StIssue;
          end
        end
        StIssue: begin
`ifdef RAM_SCHED_CLOSE_PAGE_EN
          // Auto-precharge closes the bank; hold off the next access for tRP.
          open_q[lat_bank] <= 1'b0;
          wait_q           <= IssueWait;
          state_q          <= StWaitRp;
`else
          state_q <= StIdle;
`endif
        end
        StRefPrea, StRefWaitRp: begin
          if (state_q == StRefPrea && T_RP > 1) begin
            wait_q  <= RpWait;
            state_q <= StRefWaitRp;
          end else if (state_q == StRefWaitRp && wait_q != 8'd0) begin
            wait_q <= wait_q - 8'd1;
          end else begin
            cmd_valid_q   <= 1'b1;
            cmd_q         <= CmdRef;
            open_q        <= '0;
            ref_pending_q <= 1'b0;
            ref_cnt_q     <= '0;
            state_q       <= StRef;
          end
        end
        StRef: begin
          if (T_RFC > 1) begin
            wait_q  <= RfcWait;
            state_q <= StWaitRfc;
          end else begin
            state_q <= StIdle;
          end
        end
        StWaitRfc: begin
          if (wait_q != 8'd0) wait_q  <= wait_q - 8'd1;
          else                state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd          = cmd_q;
  assign cmd_bank     = cmd_bank_q;
  assign cmd_row      = cmd_row_q;
  assign cmd_col      = cmd_col_q;
  assign cmd_auto_pre = cmd_auto_pre_q;
  assign cmd_wdata    = cmd_wdata_q;

  // Read data is passed straight through in the cycle the response emerges.
  assign rsp_valid = rd_vld_q[RD_LAT-1];
  assign rsp_id    = rd_vld_q[RD_LAT-1] & rd_id_q[RD_LAT-1];
  assign rsp_rdata = rd_vld_q[RD_LAT-1] ? dram_rdata : 16'h0000;

endmodule
